uart_byte_fifo: RTL

Elastic byte buffer between the UART receiver and the UART transmitter. It drains received bytes from `UartRx` through the `ready_o`/`clear_ready_i` handshake, stores them in a circular FIFO, and replays them to `UartTx` through the `write_i`/`busy_o` handshake. In the loopback design it replaces the direct `ready_o & !busy_o` coupling, so back-to-back received bytes are absorbed while the transmitter is busy. It also reports fill level and overrun.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_byte_fifo_if.sv | 30 +++
 rtl/uart_fifo_mem.sv | 22 ++
 rtl/uart_byte_fifo.sv | 126 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte buffer: FSM state types and default sizing.
package uart_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH_LOG2 = 4;

  typedef enum logic {
    RX_IDLE,
    RX_WAIT_LOW
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE
  } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo_if.sv
// Handshake bundle between UartRx, the byte FIFO and UartTx, plus status outputs.
interface uart_byte_fifo_if #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH_LOG2 = uart_pkg::DEPTH_LOG2
);

  logic [DATA_WIDTH-1:0] rx_data_i;
  logic                  rx_ready_i;
  logic                  rx_clear_ready_o;
  logic [DATA_WIDTH-1:0] tx_data_o;
  logic                  tx_write_o;
  logic                  tx_busy_i;
  logic                  clear_overrun_i;
  logic [DEPTH_LOG2:0]   count_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  overrun_o;

  // The FIFO itself is the slave; the surrounding UART logic is the master.
  modport slave (
    input  rx_data_i, rx_ready_i, tx_busy_i, clear_overrun_i,
    output rx_clear_ready_o, tx_data_o, tx_write_o, count_o, empty_o, full_o, overrun_o
  );

  modport master (
    output rx_data_i, rx_ready_i, tx_busy_i, clear_overrun_i,
    input  rx_clear_ready_o, tx_data_o, tx_write_o, count_o, empty_o, full_o, overrun_o
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Dual-port storage array: synchronous write, combinational read, no reset.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH_LOG2 = uart_pkg::DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic [DEPTH_LOG2-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DEPTH_LOG2-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Elastic byte buffer between UartRx and UartTx with fill level and sticky overrun.
module uart_byte_fifo #(
  parameter int DATA_WIDTH   = uart_pkg::DATA_WIDTH,
  parameter int DEPTH_LOG2   = uart_pkg::DEPTH_LOG2,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic           clock_i,
  input logic           reset_i,
  uart_byte_fifo_if.slave bus
);
  import uart_pkg::*;

  localparam int DEPTH   = 2**DEPTH_LOG2;
  localparam int TIMER_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE      = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL     = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TIMER_W-1:0]    TIMER_ONE    = 1;
  localparam logic [TIMER_W-1:0]    TIMEOUT_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

  rx_state_t             rx_state;
  tx_state_t             tx_state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [TIMER_W-1:0]    timer;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_write;
  logic                  clear_ready;
  logic                  overrun;
  logic                  empty;
  logic                  full;
  logic                  rx_take;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign rx_take = (rx_state == RX_IDLE) && bus.rx_ready_i;
  assign pop     = (tx_state == TX_IDLE) && !empty && !bus.tx_busy_i;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push    = rx_take && (!full || pop);
  assign drop    = rx_take && !push;

  uart_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) mem_inst (
    .clock      (clock_i),
    .write_en   (push),
    .write_addr (wr_ptr),
    .write_data (bus.rx_data_i),
    .read_addr  (rd_ptr),
    .read_data  (head)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) overrun <= 1'b1;
      else if (bus.clear_overrun_i) overrun <= 1'b0;
    end
  end

  // One push per ready episode: wait for ready to fall before accepting again.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_state    <= RX_IDLE;
      clear_ready <= 1'b0;
    end else begin
      clear_ready <= rx_take;
      case (rx_state)
        RX_IDLE:     if (bus.rx_ready_i) rx_state <= RX_WAIT_LOW;
        RX_WAIT_LOW: if (!bus.rx_ready_i) rx_state <= RX_IDLE;
        default:     rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      tx_state <= TX_IDLE;
      tx_write <= 1'b0;
      tx_data  <= '0;
      timer    <= '0;
    end else begin
      tx_write <= pop;
      if (pop) tx_data <= head;
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_state <= TX_WAIT_BUSY;
            timer    <= '0;
          end
        end
        // A transmitter that never raises busy is assumed to have taken the byte.
        TX_WAIT_BUSY: begin
          if (bus.tx_busy_i) tx_state <= TX_WAIT_IDLE;
          else if (timer == TIMEOUT_LAST) tx_state <= TX_IDLE;
          else timer <= timer + TIMER_ONE;
        end
        TX_WAIT_IDLE: if (!bus.tx_busy_i) tx_state <= TX_IDLE;
        default:      tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.rx_clear_ready_o = clear_ready;
  assign bus.tx_data_o        = tx_data;
  assign bus.tx_write_o       = tx_write;
  assign bus.count_o          = count;
  assign bus.empty_o          = empty;
  assign bus.full_o           = full;
  assign bus.overrun_o        = overrun;

endmodule
